// File: rtl/partial_case_assign_core.sv
// ----------------------------------------------------------------------------
// partial_case_assign_core
//
// Three-way data router with a held output. The route select picks where the
// data inputs go; in the hold route, x is sourced from a clocked register that
// keeps the last routed x value, so no latch is needed to retain it.
//
//   i_sel | o_x        | o_y
//   ------+------------+------
//   00    | i_i0       | i_i2
//   01    | held x     | i_i0
//   1x    | i_i1       | i_i1
//
// Configuration macro: PCA_OUTPUT_REG_EN
//   undefined : o_x/o_y/o_x_hold_active are combinational; held x comes from
//               r_x_q, which captures the routed x on every clock edge.
//   defined   : all three outputs are registered (1-cycle latency, async
//               clear); the registered o_x is itself the hold source.
//
// Ports
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   i_sel[1:0]      in   route select
//   i_i0/i_i1/i_i2  in   data inputs, WIDTH bits
//   o_x, o_y        out  routed outputs, WIDTH bits
//   o_x_hold_active out  high while x is sourced from the hold register
// ----------------------------------------------------------------------------
module partial_case_assign_core #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       i_sel,
   input  logic [WIDTH-1:0] i_i0,
   input  logic [WIDTH-1:0] i_i1,
   input  logic [WIDTH-1:0] i_i2,
   output logic [WIDTH-1:0] o_x,
   output logic [WIDTH-1:0] o_y,
   output logic             o_x_hold_active
);

   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_y;
   logic             w_hold_active;
   logic [WIDTH-1:0] w_hold_src;

   // Every output is given a value before the case, so nothing is inferred as
   // a latch. Unknown select codes fall through to the default route.
   always_comb begin
      w_x           = i_i1;
      w_y           = i_i1;
      w_hold_active = 1'b0;
      case (i_sel)
         2'b00: begin
            w_x = i_i0;
            w_y = i_i2;
         end
         2'b01: begin
            w_x           = w_hold_src;
            w_y           = i_i0;
            w_hold_active = 1'b1;
         end
         default: begin
            w_x           = i_i1;
            w_y           = i_i1;
            w_hold_active = 1'b0;
         end
      endcase
   end

`ifdef PCA_OUTPUT_REG_EN

   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic             r_hold_active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x           <= '0;
         r_y           <= '0;
         r_hold_active <= 1'b0;
      end else begin
         r_x           <= w_x;
         r_y           <= w_y;
         r_hold_active <= w_hold_active;
      end
   end

   // The registered x already holds the last routed x, so it doubles as the
   // hold register.
   assign w_hold_src      = r_x;
   assign o_x             = r_x;
   assign o_y             = r_y;
   assign o_x_hold_active = r_hold_active;

`else

   logic [WIDTH-1:0] r_x_q;

   // Recapturing w_x in the hold route feeds r_x_q back onto itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x_q <= '0;
      end else begin
         r_x_q <= w_x;
      end
   end

   assign w_hold_src      = r_x_q;
   assign o_x             = w_x;
   assign o_y             = w_y;
   assign o_x_hold_active = w_hold_active;

`endif

endmodule

// File: tb/tb_partial_case_assign_core.sv
module tb_partial_case_assign_core;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   sel;
   logic [W-1:0] i0, i1, i2;
   logic [W-1:0] x, y;
   logic         hact;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         h;
      bit           slot;   // 0: sampled at negedge, 1: sampled 3ns after negedge
      string        tag;
   } exp_t;

   exp_t q[$];

   // Reference model state: the value x will show when the hold route is used
   // (combinational build), or the three output registers (registered build).
   logic [W-1:0] m_held;
   logic [W-1:0] m_x, m_y;
   logic         m_h;

   partial_case_assign_core #(.WIDTH(W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_sel           (sel),
      .i_i0            (i0),
      .i_i1            (i1),
      .i_i2            (i2),
      .o_x             (x),
      .o_y             (y),
      .o_x_hold_active (hact)
   );

   always #5 clk = ~clk;

   // Routing rule: returns {x, y, hold_active}.
   function automatic logic [2*W:0] route(input logic [1:0] s,
                                          input logic [W-1:0] a, b, c, h);
      if (s == 2'b00)      return {a, c, 1'b0};
      else if (s == 2'b01) return {h, a, 1'b1};
      else                 return {b, b, 1'b0};
   endfunction

   task automatic model_edge();
      logic [2*W:0] r;
`ifdef PCA_OUTPUT_REG_EN
      if (rst_n) begin
         r   = route(sel, i0, i1, i2, m_x);
         m_x = r[2*W:W+1];
         m_y = r[W:1];
         m_h = r[0];
      end
`else
      if (rst_n) begin
         r      = route(sel, i0, i1, i2, m_held);
         m_held = r[2*W:W+1];
      end
`endif
   endtask

   task automatic model_clear();
      m_held = '0;
      m_x    = '0;
      m_y    = '0;
      m_h    = 1'b0;
   endtask

   task automatic push(input bit slot, input string tag);
      exp_t         e;
      logic [2*W:0] r;
`ifdef PCA_OUTPUT_REG_EN
      r = {m_x, m_y, m_h};
`else
      r = route(sel, i0, i1, i2, m_held);
`endif
      e.x    = r[2*W:W+1];
      e.y    = r[W:1];
      e.h    = r[0];
      e.slot = slot;
      e.tag  = tag;
      q.push_back(e);
   endtask

   // One full cycle of stimulus: inputs change just after the rising edge.
   task automatic apply(input bit r, input logic [1:0] s,
                        input logic [W-1:0] a, b, c, input string tag);
      @(posedge clk);
      model_edge();
      #1;
      rst_n = r;
      sel   = s;
      i0    = a;
      i1    = b;
      i2    = c;
      if (!r) model_clear();
      push(1'b0, tag);
   endtask

   // Change i0 in the second half of the current cycle, before the next edge.
   task automatic midchange(input logic [W-1:0] a, input string tag);
      @(negedge clk);
      #1;
      i0 = a;
      push(1'b1, tag);
   endtask

   task automatic check(input exp_t e);
      checks++;
      if (x !== e.x || y !== e.y || hact !== e.h) begin
         errors++;
         $display("FAIL %s: got x=%h y=%h hold=%b, expected x=%h y=%h hold=%b",
                  e.tag, x, y, hact, e.x, e.y, e.h);
      end
   endtask

   // Monitor: independent of stimulus, checks whatever expectation is due.
   always begin
      @(negedge clk);
      if (q.size() > 0 && q[0].slot == 1'b0) check(q.pop_front());
      #3;
      if (q.size() > 0 && q[0].slot == 1'b1) check(q.pop_front());
   end

   initial begin
      logic [1:0]   s;
      logic [W-1:0] a, b, c;
      bit           r;

      model_clear();
      rst_n = 1'b0;
      sel   = 2'b01;
      i0    = 4'h1;
      i1    = 4'h1;
      i2    = 4'h1;

      // Reset with the hold route selected: held x is zero.
      apply(1'b0, 2'b01, 4'h1, 4'h1, 4'h1, "reset_hold");
      apply(1'b0, 2'b01, 4'h1, 4'h1, 4'h1, "reset_hold2");

      // Route 00, then i0 drops within the same cycle.
      apply(1'b1, 2'b00, 4'h1, 4'h0, 4'h0, "route00");
      midchange(4'h0, "route00_i0_fall");
      apply(1'b1, 2'b00, 4'h0, 4'h0, 4'h0, "route00_low");

      // Capture x=1 then hold while i0 toggles.
      apply(1'b1, 2'b00, 4'h1, 4'h0, 4'h0, "hold_capture");
      apply(1'b1, 2'b01, 4'h1, 4'h0, 4'h0, "hold_c1");
      apply(1'b1, 2'b01, 4'h0, 4'h0, 4'h0, "hold_c2");
      apply(1'b1, 2'b01, 4'h1, 4'h0, 4'h0, "hold_c3");
      apply(1'b1, 2'b01, 4'h0, 4'h0, 4'h0, "hold_c4");
      // Leaving hold: x follows the new route at once.
      apply(1'b1, 2'b10, 4'h0, 4'h7, 4'h0, "hold_exit");

      // Default branch with i1 toggling.
      for (int k = 0; k < 4; k++)
         apply(1'b1, 2'b10, 4'h0, (k % 2) ? 4'hF : 4'h0, 4'h5, "default10");
      for (int k = 0; k < 4; k++)
         apply(1'b1, 2'b11, 4'h0, (k % 2) ? 4'h0 : 4'hF, 4'h5, "default11");

      // Reset in the middle of a hold: x clears immediately and stays clear.
      apply(1'b1, 2'b00, 4'hB, 4'h0, 4'h0, "mid_hold_load");
      apply(1'b1, 2'b01, 4'h2, 4'h0, 4'h0, "mid_hold");
      apply(1'b0, 2'b01, 4'h3, 4'h0, 4'h0, "mid_hold_reset");
      apply(1'b1, 2'b01, 4'h4, 4'h0, 4'h0, "mid_hold_release");
      apply(1'b1, 2'b01, 4'h5, 4'h0, 4'h0, "mid_hold_after1");
      apply(1'b1, 2'b01, 4'h6, 4'h0, 4'h0, "mid_hold_after2");

      // Free-running select sweep with inputs toggling at unrelated periods.
      for (int c2 = 0; c2 < 48; c2++) begin
         s = 2'((c2 / 2) % 4);
         a = ((c2 / 3) % 2) ? 4'hA : 4'h5;
         b = ((c2 / 5) % 2) ? 4'h3 : 4'hC;
         c = ((c2 / 7) % 2) ? 4'h9 : 4'h6;
         apply(1'b1, s, a, b, c, "sweep");
      end

      // Random traffic with occasional resets.
      for (int k = 0; k < 300; k++) begin
         s = 2'($urandom_range(0, 3));
         a = W'($urandom);
         b = W'($urandom);
         c = W'($urandom);
         r = ($urandom_range(0, 24) != 0);
         apply(r, s, a, b, c, "random");
         if ($urandom_range(0, 5) == 0) midchange(W'($urandom), "random_mid");
      end

      // Drain the scoreboard with a bounded wait.
      for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/partial_case_assign_core.md
PARTIAL_CASE_ASSIGN_CORE -- requirements
Module: partial_case_assign

Interface
REQ-001 Parameter: WIDTH, default 1, width of the data inputs i0/i1/i2 and outputs x/y.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 sel  input  2  route select.
REQ-005 i0  input  WIDTH  data input 0.
REQ-006 i1  input  WIDTH  data input 1.
REQ-007 i2  input  WIDTH  data input 2.
REQ-008 x  output  WIDTH  routed output x.
REQ-009 y  output  WIDTH  routed output y.
REQ-010 x_hold_active  output  1  high while x is driven from the hold register (sel==2'b01).

Function
REQ-011 Routing for sel=2'b00 SHALL be: x=i0, y=i2.
REQ-012 Routing for sel=2'b01 SHALL be: y=i0, with x equal to the hold register value (the last x value captured).
REQ-013 Routing for sel=2'b10 and sel=2'b11 (default branch) SHALL be: x=i1, y=i1.
REQ-014 Hold register x_q SHALL capture the routed x value on every rising clk edge while rst_n is high.
  - In sel==01 it recaptures its own value, so it holds.
REQ-015 The design SHALL infer no latch; the retained value of x exists only in the clocked register x_q.
REQ-016 x_hold_active SHALL equal (sel==2'b01) combinationally.
REQ-017 Without the configuration macro, x and y SHALL be combinational from sel/i*/x_q with zero latency.
  - Exception: held-x tracks the value at the last clock edge.
REQ-018 On a sel change from 01 to any other code, x SHALL follow the new routing in the same cycle.
REQ-019 X/Z on sel SHALL be treated as the default branch (x=y=i1).

Reset
REQ-020 While rst_n is low, x_q SHALL be 0.
  - Entering sel==01 directly after reset SHALL give x=0.
REQ-021 Reset assertion SHALL take effect immediately, without waiting for clk.
REQ-022 Reset deassertion SHALL take effect at the first rising clk edge after rst_n goes high.
REQ-023 Reset asserted mid-hold (sel==01) SHALL force x to 0 immediately.
  - x SHALL stay 0 while sel remains 01 after release.

Configuration
REQ-024 Macro PCA_OUTPUT_REG_EN SHALL select the output timing.
  - Defined: x, y and x_hold_active are registered with 1-cycle latency after the routing logic, and reset to 0 asynchronously.
  - In registered mode, held-x SHALL use the registered x output as its hold source.
  - Undefined: outputs are combinational per REQ-017.

Verification
REQ-025 Reset: rst_n=0, sel=01, i0=1, i1=1, i2=1 -> x=0, y=1 (combinational build), x_hold_active=1.
REQ-026 Route 00: sel=00, i0=1, i2=0 -> x=1, y=0; then i0=0 -> x=0 within the same cycle.
REQ-027 Hold, step 1: sel=00 with i0=1 for one clk edge.
  - Then switch to sel=01 and toggle i0 1->0.
  - Required: x stays 1 and y follows i0 (1 then 0) for 4 cycles.
REQ-028 Default branch: sel=10 then sel=11 with i1 toggling 0/1 -> x=y=i1 every cycle; x_hold_active=0.
REQ-029 Free-running sel sweep: sel counter 00->01->10->11 every 2 clk cycles, with i0, i1, i2 toggling at unrelated periods.
  - Required: x/y match the routing model each cycle, with no X on the outputs after reset release.
REQ-030 PCA_OUTPUT_REG_EN defined: repeat REQ-026 -> x, y update one clk after the input change; async reset clears the outputs immediately.
